cfu_cmd_master: RTL and testbench
=================================

CFU_CMD_MASTER -- requirements
Module: cfu_cmd_master

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, 4, entries in each of the request and result FIFOs (power of 2, ≥2); TIMEOUT_CYCLES, 1024, maximum WAIT_RSP cycles before abort.
REQ-002 The block SHALL use one clock, clk, and a synchronous active-high reset, reset; both ports SHALL be listed first.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  upstream command offered
- req_ready  out  1  request FIFO can accept
- req_function_id  in  10  function id to issue
- req_inputs_0  in  32  operand 0
- req_inputs_1  in  32  operand 1
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  downstream pops result
- res_data  out  32  result FIFO head
- cmd_valid  out  1  CFU command valid
- cmd_ready  in  1  CFU accepts command
- cmd_payload_function_id  out  10  issued function id
- cmd_payload_inputs_0  out  32  issued operand 0
- cmd_payload_inputs_1  out  32  issued operand 1
- rsp_valid  in  1  CFU response valid
- rsp_ready  out  1  master accepts response
- rsp_payload_outputs_0  in  32  CFU response data
- busy  out  1  state not IDLE or request FIFO non-empty
- timeout_err  out  1  sticky: a response timed out

Function
REQ-004 The block SHALL act as the initiator of the CFU cmd/rsp protocol, with at most one command outstanding.
REQ-005 A request SHALL be pushed when req_valid && req_ready; req_ready SHALL equal !request_fifo_full, independent of a same-cycle pop.
REQ-006 The FSM SHALL have states IDLE, ISSUE and WAIT_RSP.
REQ-007 In IDLE with the request FIFO non-empty, the FSM SHALL pop the head into payload registers and enter ISSUE on the next cycle; IDLE plus push of an empty FIFO SHALL give cmd_valid 2 cycles after the push.
REQ-008 In ISSUE, cmd_valid SHALL be 1 and the payload SHALL stay stable until cmd_valid && cmd_ready, after which the FSM SHALL enter WAIT_RSP.
REQ-009 rsp_ready SHALL be !result_fifo_full in ISSUE and WAIT_RSP, and 0 in IDLE.
REQ-010 A response SHALL be accepted on rsp_valid && rsp_ready, either in WAIT_RSP or in ISSUE in the same cycle as the cmd handshake (zero-latency responder).
REQ-011 On acceptance, rsp_payload_outputs_0 SHALL be pushed to the result FIFO and the FSM SHALL go to IDLE, or directly to ISSUE with a new pop if the request FIFO is non-empty (back-to-back).
REQ-012 rsp_valid arriving in IDLE SHALL be ignored.
REQ-013 A timeout counter SHALL clear on entry to WAIT_RSP and increment each WAIT_RSP cycle without acceptance.
REQ-014 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL set timeout_err (sticky), push nothing and return to IDLE.
REQ-015 While the result FIFO is full, rsp_ready SHALL be 0, the FSM SHALL hold WAIT_RSP and the timeout counter SHALL freeze.
REQ-016 res_valid SHALL equal !result_fifo_empty and res_data SHALL show the head; the FIFO SHALL pop on res_valid && res_ready.
REQ-017 Push and pop in the same cycle on a non-empty, non-full result FIFO SHALL leave the occupancy unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count distinguishing full from empty.
REQ-019 The response order SHALL equal the request order.

Reset
REQ-020 On reset, the FSM SHALL go to IDLE and both FIFOs SHALL be emptied.
REQ-021 On reset, cmd_valid, rsp_ready, res_valid, busy and timeout_err SHALL be 0, and the payload outputs and the timeout counter SHALL be 0.
REQ-022 A reset mid-transaction SHALL abandon the outstanding command with no result pushed, and timeout_err SHALL clear only on reset.

Structure
REQ-023 Package cfu_master_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT_RSP), a 74-bit request record (function_id, inputs_0, inputs_1), and the default FIFO_DEPTH and TIMEOUT_CYCLES.
REQ-024 A sub-module sync_fifo (parameterised width and depth, synchronous active-high reset) SHALL be instantiated twice: request, 74 bits; result, 32 bits.

Verification
REQ-025 Push (fid=0, 0x00000080, 0x00000010) with a responder that returns 0 one cycle after the cmd handshake -> cmd_valid high 2 cycles after the push, one result 0x00000000, busy low afterwards.
REQ-026 Four back-to-back pushes with fid=7 and a zero-latency responder echoing inputs_0 = 1,2,3,4 -> results 1,2,3,4 in order, with no IDLE cycle between commands.
REQ-027 Hold cmd_ready=0 for 5 cycles -> cmd_valid and the payload stay stable for all 5 cycles, and exactly one command is issued.
REQ-028 res_ready=0, 5 requests with FIFO_DEPTH=4 -> 4 results stored, rsp_ready=0 with the FSM in WAIT_RSP; raising res_ready then yields the 5th result.
REQ-029 Responder never answers, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT_RSP cycles, no result, FSM in IDLE, next request issued normally.
REQ-030 Assert reset in WAIT_RSP with 2 requests queued -> all outputs 0 next cycle, FIFOs empty, and a late rsp_valid is ignored.

Source files
------------

// File: rtl/cfu_master_pkg.sv
// Shared types and defaults for the CFU command master.
package cfu_master_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_e;

  // 74-bit queued request: function id plus two operands.
  typedef struct packed {
    logic [9:0]  function_id;
    logic [31:0] inputs_0;
    logic [31:0] inputs_1;
  } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers wrap modulo DEPTH, occupancy count separates full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  // Drive zero while empty so the head never shows stale or uninitialised data.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cfu_cmd_master.sv
// CFU cmd/rsp initiator: queues requests, issues one command at a time, collects results.
module cfu_cmd_master
  import cfu_master_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  req_t          req_in, req_head, pay_q, pay_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          terr_q, terr_d;
  logic          req_full, req_empty, req_push, req_pop;
  logic          res_full, res_empty, res_push, res_pop;
  logic          cmd_fire, rsp_fire, done;

  assign req_in.function_id = req_function_id;
  assign req_in.inputs_0    = req_inputs_0;
  assign req_in.inputs_1    = req_inputs_1;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign req_ready = !req_full;
  assign req_push  = req_valid && !req_full;
  assign res_valid = !res_empty;
  assign res_pop   = res_valid && res_ready;

  assign cmd_payload_function_id = pay_q.function_id;
  assign cmd_payload_inputs_0    = pay_q.inputs_0;
  assign cmd_payload_inputs_1    = pay_q.inputs_1;
  assign busy                    = (state_q != IDLE) || !req_empty;
  assign timeout_err             = terr_q;

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_push),
    .push_data (req_in),
    .pop       (req_pop),
    .pop_data  (req_head),
    .full      (req_full),
    .empty     (req_empty)
  );

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (res_push),
    .push_data (rsp_payload_outputs_0),
    .pop       (res_pop),
    .pop_data  (res_data),
    .full      (res_full),
    .empty     (res_empty)
  );

  // Next-state, handshake and timeout logic.
  always_comb begin
    state_d   = state_q;
    pay_d     = pay_q;
    timer_d   = timer_q;
    terr_d    = terr_q;
    req_pop   = 1'b0;
    res_push  = 1'b0;
    done      = 1'b0;
    cmd_valid = (state_q == ISSUE);
    rsp_ready = (state_q != IDLE) && !res_full;
    cmd_fire  = cmd_valid && cmd_ready;
    // A response in ISSUE counts only alongside the cmd handshake (zero-latency responder).
    rsp_fire  = rsp_valid && rsp_ready && ((state_q == WAIT_RSP) || cmd_fire);

    unique case (state_q)
      IDLE: begin
        if (!req_empty) begin
          req_pop = 1'b1;
          pay_d   = req_head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_fire) begin
          if (rsp_fire) begin
            done = 1'b1;
          end else begin
            state_d = WAIT_RSP;
            timer_d = '0;
          end
        end
      end
      WAIT_RSP: begin
        if (rsp_fire) begin
          done = 1'b1;
        end else if (!res_full) begin
          // Counter freezes while the result FIFO is full.
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            terr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Completed transaction: store result and chain straight into the next request if queued.
    if (done) begin
      res_push = 1'b1;
      if (!req_empty) begin
        req_pop = 1'b1;
        pay_d   = req_head;
        state_d = ISSUE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, payload, timer and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pay_q   <= '0;
      timer_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      timer_q <= timer_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_master.sv
// Directed self-checking bench for cfu_cmd_master.
module tb_cfu_cmd_master;
  import cfu_master_pkg::*;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [9:0]  req_function_id;
  logic [31:0] req_inputs_0, req_inputs_1;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy, timeout_err;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [31:0] got_q [$];

  // Responder controls: 0 silent, 1 answers one cycle after handshake, 2 zero-latency.
  int          rsp_mode;
  logic        rsp_echo, rsp_force;
  logic        pend_q;
  logic [31:0] pend_data;

  cfu_cmd_master #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_function_id         (req_function_id),
    .req_inputs_0            (req_inputs_0),
    .req_inputs_1            (req_inputs_1),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .busy                    (busy),
    .timeout_err             (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder outputs.
  always_comb begin
    rsp_valid = pend_q || rsp_force || ((rsp_mode == 2) && cmd_valid && cmd_ready);
    if (pend_q)         rsp_payload_outputs_0 = pend_data;
    else if (rsp_force) rsp_payload_outputs_0 = 32'hdead_beef;
    else if (rsp_echo)  rsp_payload_outputs_0 = cmd_payload_inputs_0;
    else                rsp_payload_outputs_0 = 32'h0;
  end

  // Responder pending state: holds a response until the master accepts it.
  always @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      if (pend_q && rsp_ready) pend_q <= 1'b0;
      if ((rsp_mode != 0) && cmd_valid && cmd_ready && !((rsp_mode == 2) && rsp_ready)) begin
        pend_q    <= 1'b1;
        pend_data <= rsp_echo ? cmd_payload_inputs_0 : 32'h0;
      end
    end
  end

  // Monitor: records popped results and command handshakes.
  always @(posedge clk) begin
    if (!reset && res_valid && res_ready) got_q.push_back(res_data);
    if (!reset && cmd_valid && cmd_ready) hs_count <= hs_count + 1;
  end

  task automatic drive_req(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1);
    req_valid       = 1'b1;
    req_function_id = fid;
    req_inputs_0    = in0;
    req_inputs_1    = in1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready: got %b want 0", rsp_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== 74'h0) begin
      errors++; $display("FAIL reset_payload: got %h/%h/%h want 0", cmd_payload_function_id,
                         cmd_payload_inputs_0, cmd_payload_inputs_1);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    int base_got;
    logic [31:0] v;
    base_got = got_q.size();
    rsp_mode = 1; rsp_echo = 1'b0; cmd_ready = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    drive_req(10'd0, 32'h0000_0080, 32'h0000_0010);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_cmd_early: got %b want 0", cmd_valid); end
    @(negedge clk);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL single_cmd_valid: got %b want 1", cmd_valid); end
    checks++; if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !==
                  {10'd0, 32'h0000_0080, 32'h0000_0010}) begin
      errors++; $display("FAIL single_payload: got %h/%h/%h want 000/00000080/00000010",
                         cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
    end
    repeat (6) @(negedge clk);
    checks++; if (got_q.size() - base_got != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", got_q.size() - base_got);
    end
    v = (got_q.size() > base_got) ? got_q[base_got] : 32'hffff_ffff;
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL single_result: got %h want 00000000", v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base_got;
    logic exp_v;
    logic [31:0] v;
    base_got = got_q.size();
    rsp_mode = 2; rsp_echo = 1'b1; cmd_ready = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_v = (i >= 2) && (i <= 5);
      checks++; if (cmd_valid !== exp_v) begin
        errors++; $display("FAIL b2b_cmd_valid[%0d]: got %b want %b", i, cmd_valid, exp_v);
      end
      if (exp_v) begin
        checks++; if (cmd_payload_inputs_0 !== 32'(i - 1)) begin
          errors++; $display("FAIL b2b_payload[%0d]: got %h want %h", i, cmd_payload_inputs_0, 32'(i - 1));
        end
      end
      if (i < 4) drive_req(10'd7, 32'(i + 1), 32'h0);
      else req_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() - base_got != 4) begin
      errors++; $display("FAIL b2b_count: got %0d want 4", got_q.size() - base_got);
    end
    for (int k = 0; k < 4; k++) begin
      v = (got_q.size() > base_got + k) ? got_q[base_got + k] : 32'hffff_ffff;
      checks++; if (v !== 32'(k + 1)) begin
        errors++; $display("FAIL b2b_result[%0d]: got %h want %h", k, v, 32'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    int base_hs, base_got;
    logic [31:0] v;
    base_hs = hs_count; base_got = got_q.size();
    rsp_mode = 1; rsp_echo = 1'b1; cmd_ready = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    drive_req(10'd3, 32'ha5a5_0001, 32'h5a5a_0002);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, cmd_valid); end
      checks++; if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !==
                    {10'd3, 32'ha5a5_0001, 32'h5a5a_0002}) begin
        errors++; $display("FAIL stall_payload[%0d]: got %h/%h/%h want 003/a5a50001/5a5a0002", i,
                           cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
      end
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL stall_after: got %b want 0", cmd_valid); end
    repeat (5) @(negedge clk);
    checks++; if (hs_count - base_hs != 1) begin
      errors++; $display("FAIL stall_hs: got %0d want 1", hs_count - base_hs);
    end
    v = (got_q.size() > base_got) ? got_q[base_got] : 32'hffff_ffff;
    checks++; if (v !== 32'ha5a5_0001) begin errors++; $display("FAIL stall_result: got %h want a5a50001", v); end
  endtask

  task automatic test_backpressure();
    int base_got;
    logic [31:0] v;
    base_got = got_q.size();
    rsp_mode = 1; rsp_echo = 1'b1; cmd_ready = 1'b1; res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 1", k, req_ready); end
      drive_req(10'd2, 32'h10 + 32'(k), 32'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (dut.u_res_fifo.count_q !== 3'd4) begin
      errors++; $display("FAIL bp_stored: got %0d want 4", dut.u_res_fifo.count_q);
    end
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h10) begin
      errors++; $display("FAIL bp_head: got %b/%h want 1/00000010", res_valid, res_data);
    end
    checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_rsp_ready: got %b want 0", rsp_ready); end
    checks++; if (dut.state_q !== WAIT_RSP) begin
      errors++; $display("FAIL bp_state: got %0d want %0d", int'(dut.state_q), int'(WAIT_RSP));
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL bp_timer_freeze: got %b want 0", timeout_err); end
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (got_q.size() - base_got != 5) begin
      errors++; $display("FAIL bp_count: got %0d want 5", got_q.size() - base_got);
    end
    for (int k = 0; k < 5; k++) begin
      v = (got_q.size() > base_got + k) ? got_q[base_got + k] : 32'hffff_ffff;
      checks++; if (v !== 32'h10 + 32'(k)) begin
        errors++; $display("FAIL bp_result[%0d]: got %h want %h", k, v, 32'h10 + 32'(k));
      end
    end
  endtask

  task automatic test_timeout();
    int base_got;
    logic [31:0] v;
    base_got = got_q.size();
    rsp_mode = 0; rsp_echo = 1'b1; cmd_ready = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    drive_req(10'd1, 32'h33, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    // Handshake ends cycle 2; sixteen WAIT_RSP cycles occupy cycles 3..18.
    repeat (17) @(negedge clk);
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_early: got err=%b busy=%b want 0/1", timeout_err, busy);
    end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", timeout_err); end
    checks++; if (dut.state_q !== IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL to_idle: got state=%0d busy=%b want 0/0", int'(dut.state_q), busy);
    end
    checks++; if (res_valid !== 1'b0 || got_q.size() != base_got) begin
      errors++; $display("FAIL to_noresult: got res_valid=%b n=%0d want 0/0", res_valid, got_q.size() - base_got);
    end
    rsp_mode = 1;
    @(negedge clk);
    drive_req(10'd1, 32'h44, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    v = (got_q.size() > base_got) ? got_q[base_got] : 32'hffff_ffff;
    checks++; if (v !== 32'h44) begin errors++; $display("FAIL to_next: got %h want 00000044", v); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    rsp_mode = 0; cmd_ready = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_req(10'd5, 32'h100 + 32'(k), 32'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== WAIT_RSP || dut.u_req_fifo.count_q !== 3'd2) begin
      errors++; $display("FAIL rm_pre: got state=%0d queued=%0d want %0d/2", int'(dut.state_q),
                         dut.u_req_fifo.count_q, int'(WAIT_RSP));
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_valid, rsp_ready, res_valid, busy, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL rm_outputs: got %b want 00000", {cmd_valid, rsp_ready, res_valid, busy, timeout_err});
    end
    checks++; if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== 74'h0) begin
      errors++; $display("FAIL rm_payload: got %h/%h/%h want 0", cmd_payload_function_id,
                         cmd_payload_inputs_0, cmd_payload_inputs_1);
    end
    checks++; if (dut.u_req_fifo.count_q !== 3'd0 || dut.u_res_fifo.count_q !== 3'd0) begin
      errors++; $display("FAIL rm_fifos: got %0d/%0d want 0/0", dut.u_req_fifo.count_q, dut.u_res_fifo.count_q);
    end
    reset = 1'b0;
    rsp_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || rsp_ready !== 1'b0) begin
        errors++; $display("FAIL rm_late_rsp[%0d]: got res_valid=%b busy=%b rsp_ready=%b want 0/0/0",
                           i, res_valid, busy, rsp_ready);
      end
    end
    rsp_force = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
    res_ready = 1'b1; cmd_ready = 1'b1; rsp_mode = 0; rsp_echo = 1'b0; rsp_force = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
